// File: rtl/hpm_sample_sequencer.sv
// Periodic HPM counter sampler. It shares the perf-counter read port with the
// CSR unit, and CSR accesses always win. On every period expiry it walks the
// selected mhpmcounters and streams each one out as a valid/ready beat.
module hpm_sample_sequencer #(
  parameter int NumCounters = 6,
  parameter int OvfWidth    = 16,
  localparam int IdxW  = (NumCounters > 1) ? $clog2(NumCounters) : 1,
  localparam int ScanW = $clog2(NumCounters + 1)
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   csr_req_i,
  input  logic [11:0]            csr_addr_i,
  input  logic                   csr_we_i,
  input  logic [63:0]            csr_wdata_i,
  output logic                   csr_gnt_o,
  output logic [63:0]            csr_rdata_o,
  input  logic                   cfg_en_i,
  input  logic [31:0]            cfg_period_i,
  input  logic [NumCounters-1:0] cfg_mask_i,
  output logic [11:0]            pc_addr_o,
  output logic                   pc_we_o,
  output logic [63:0]            pc_wdata_o,
  input  logic [63:0]            pc_rdata_i,
  output logic                   smp_valid_o,
  input  logic                   smp_ready_i,
  output logic [IdxW-1:0]        smp_idx_o,
  output logic [63:0]            smp_data_o,
  output logic                   smp_last_o,
  output logic [15:0]            smp_seq_o,
  output logic [OvfWidth-1:0]    overrun_o,
  output logic                   busy_o
);

  typedef enum logic [1:0] {IDLE, COUNT, SCAN, SEND} state_e;

  state_e                 state_q, state_d;
  logic [31:0]            timer_q, timer_d;
  logic [ScanW-1:0]       idx_q, idx_d;
  logic [NumCounters-1:0] scan_mask_q, scan_mask_d;
  logic [63:0]            smp_data_q, smp_data_d;
  logic [IdxW-1:0]        smp_idx_q, smp_idx_d;
  logic                   smp_last_q, smp_last_d;
  logic [15:0]            smp_seq_q, smp_seq_d;
  logic [OvfWidth-1:0]    ovf_q, ovf_d;

  logic            found;
  logic [IdxW-1:0] found_k;
  logic            found_last;
  logic [31:0]     period_eff;
  logic            expire;

  // Lowest selected counter at or above the scan cursor, and whether it is the final one.
  always_comb begin
    found      = 1'b0;
    found_k    = '0;
    found_last = 1'b1;
    for (int k = NumCounters - 1; k >= 0; k--) begin
      if (scan_mask_q[k] && (ScanW'(k) >= idx_q)) begin
        found   = 1'b1;
        found_k = IdxW'(k);
      end
    end
    for (int k = 0; k < NumCounters; k++) begin
      if (scan_mask_q[k] && (k > int'(found_k))) found_last = 1'b0;
    end
  end

  // Port arbitration: CSR requests pass straight through and never stall.
  always_comb begin
    csr_gnt_o   = csr_req_i;
    csr_rdata_o = csr_req_i ? pc_rdata_i : 64'd0;
    pc_addr_o   = 12'd0;
    pc_we_o     = 1'b0;
    pc_wdata_o  = 64'd0;
    if (csr_req_i) begin
      pc_addr_o  = csr_addr_i;
      pc_we_o    = csr_we_i;
      pc_wdata_o = csr_wdata_i;
    end else if (state_q == SCAN && found) begin
      pc_addr_o = 12'hB03 + 12'(found_k);
    end
  end

  // Next-state logic: period timer, overrun accounting and the scan walk.
  always_comb begin
    state_d     = state_q;
    timer_d     = timer_q;
    idx_d       = idx_q;
    scan_mask_d = scan_mask_q;
    smp_data_d  = smp_data_q;
    smp_idx_d   = smp_idx_q;
    smp_last_d  = smp_last_q;
    smp_seq_d   = smp_seq_q;
    ovf_d       = ovf_q;
    period_eff  = (cfg_period_i == 32'd0) ? 32'd1 : cfg_period_i;
    expire      = (state_q != IDLE) && (timer_q == 32'd1);

    if (state_q != IDLE) timer_d = expire ? period_eff : timer_q - 32'd1;
    // An expiry that lands mid-scan is dropped and only counted.
    if (expire && (state_q == SCAN || state_q == SEND) && ovf_q != '1) ovf_d = ovf_q + 1'b1;

    case (state_q)
      IDLE: begin
        if (cfg_en_i) begin
          timer_d = period_eff;
          state_d = COUNT;
        end
      end
      COUNT: begin
        if (!cfg_en_i) begin
          state_d = IDLE;
        end else if (expire) begin
          scan_mask_d = cfg_mask_i;
          idx_d       = '0;
          state_d     = SCAN;
        end
      end
      SCAN: begin
        if (!found) begin
          smp_seq_d = smp_seq_q + 16'd1;
          state_d   = cfg_en_i ? COUNT : IDLE;
        end else if (!cfg_en_i) begin
          state_d = IDLE;
        end else if (!csr_req_i) begin
          smp_data_d = pc_rdata_i;
          smp_idx_d  = found_k;
          smp_last_d = found_last;
          idx_d      = ScanW'(found_k);
          state_d    = SEND;
        end
      end
      SEND: begin
        // The beat is never withdrawn; disable is honoured only on handshake.
        if (smp_ready_i) begin
          idx_d   = ScanW'(smp_idx_q) + ScanW'(1);
          state_d = cfg_en_i ? SCAN : IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q     <= IDLE;
      timer_q     <= '0;
      idx_q       <= '0;
      scan_mask_q <= '0;
      smp_data_q  <= '0;
      smp_idx_q   <= '0;
      smp_last_q  <= 1'b0;
      smp_seq_q   <= '0;
      ovf_q       <= '0;
    end else begin
      state_q     <= state_d;
      timer_q     <= timer_d;
      idx_q       <= idx_d;
      scan_mask_q <= scan_mask_d;
      smp_data_q  <= smp_data_d;
      smp_idx_q   <= smp_idx_d;
      smp_last_q  <= smp_last_d;
      smp_seq_q   <= smp_seq_d;
      ovf_q       <= ovf_d;
    end
  end

  assign smp_valid_o = (state_q == SEND);
  assign busy_o      = (state_q == SCAN) || (state_q == SEND);
  assign smp_idx_o   = smp_idx_q;
  assign smp_data_o  = smp_data_q;
  assign smp_last_o  = smp_last_q;
  assign smp_seq_o   = smp_seq_q;
  assign overrun_o   = ovf_q;

endmodule

// File: tb/tb_hpm_sample_sequencer.sv
// Randomized and directed bench for hpm_sample_sequencer with a behavioural reference model.
module tb_hpm_sample_sequencer;
  localparam int NC = 6;

  logic        clk, rst_n;
  logic        csr_req, csr_we, en, ready;
  logic [11:0] csr_addr;
  logic [63:0] csr_wdata;
  logic [31:0] period;
  logic [NC-1:0] mask;
  logic        csr_gnt, pc_we, smp_valid, smp_last, busy;
  logic [63:0] csr_rdata, pc_wdata, pc_rdata, smp_data;
  logic [11:0] pc_addr;
  logic [2:0]  smp_idx;
  logic [15:0] smp_seq, overrun;
  logic [31:0] cyc;

  int checks = 0;
  int errors = 0;

  hpm_sample_sequencer #(.NumCounters(NC), .OvfWidth(16)) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .csr_req_i(csr_req), .csr_addr_i(csr_addr), .csr_we_i(csr_we), .csr_wdata_i(csr_wdata),
    .csr_gnt_o(csr_gnt), .csr_rdata_o(csr_rdata),
    .cfg_en_i(en), .cfg_period_i(period), .cfg_mask_i(mask),
    .pc_addr_o(pc_addr), .pc_we_o(pc_we), .pc_wdata_o(pc_wdata), .pc_rdata_i(pc_rdata),
    .smp_valid_o(smp_valid), .smp_ready_i(ready), .smp_idx_o(smp_idx), .smp_data_o(smp_data),
    .smp_last_o(smp_last), .smp_seq_o(smp_seq), .overrun_o(overrun), .busy_o(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Perf-counter port stand-in: read data tags the address with a free-running cycle count.
  always @(posedge clk) cyc <= cyc + 32'd1;
  assign pc_rdata = {pc_addr, pc_we, 19'd0, cyc};

  // Reference model: a sampler described by its rules (idle / counting / scanning / sending).
  int          m_state;   // 0 idle, 1 counting, 2 scanning, 3 sending
  logic [31:0] m_timer, m_per;
  logic [NC-1:0] m_mask;
  int          m_idx, m_k, m_nk;
  logic [63:0] m_data;
  logic        m_last, m_exp;
  logic [15:0] m_seq, m_ovf;

  always @(posedge clk) begin
    if (!rst_n) begin
      m_state = 0; m_timer = 0; m_mask = 0; m_idx = 0; m_k = 0;
      m_data = 0; m_last = 0; m_seq = 0; m_ovf = 0;
    end else begin
      m_per = (period == 0) ? 32'd1 : period;
      m_exp = (m_state != 0) && (m_timer == 32'd1);
      if (m_exp && m_state >= 2 && m_ovf != 16'hFFFF) m_ovf = m_ovf + 16'd1;
      if (m_state != 0) m_timer = m_exp ? m_per : m_timer - 32'd1;
      m_nk = -1;
      for (int j = NC - 1; j >= m_idx; j--) if (m_mask[j]) m_nk = j;
      case (m_state)
        0: if (en) begin m_timer = m_per; m_state = 1; end
        1: if (!en) m_state = 0;
           else if (m_exp) begin m_mask = mask; m_idx = 0; m_state = 2; end
        2: if (m_nk < 0) begin m_seq = m_seq + 16'd1; m_state = en ? 1 : 0; end
           else if (!en) m_state = 0;
           else if (!csr_req) begin
             m_data = {12'hB03 + 12'(m_nk), 1'b0, 19'd0, cyc};
             m_k = m_nk;
             m_last = ((m_mask >> (m_nk + 1)) == 0);
             m_idx = m_nk;
             m_state = 3;
           end
        default: if (ready) begin m_idx = m_k + 1; m_state = en ? 2 : 0; end
      endcase
    end
  end

  wire [101:0] dut_vec = {smp_valid, smp_idx, smp_data, smp_last, smp_seq, overrun, busy};
  wire [101:0] mdl_vec = {m_state == 3, 3'(m_k), m_data, m_last, m_seq, m_ovf, m_state >= 2};

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    rst_n = 0; csr_req = 0; en = 0; ready = 0; mask = 0; period = 1;
    tick(); tick();
    rst_n = 1;
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (dut_vec !== 102'd0) begin errors++; $display("FAIL reset_state got %h exp 0", dut_vec); end
    csr_req = 1; csr_addr = 12'h7A5; csr_we = 1; csr_wdata = 64'h1234; #1;
    checks++;
    if (csr_gnt !== 1'b1 || pc_addr !== 12'h7A5 || pc_we !== 1'b1 || pc_wdata !== 64'h1234) begin
      errors++; $display("FAIL reset_csr_pass gnt=%b addr=%h we=%b wd=%h", csr_gnt, pc_addr, pc_we, pc_wdata);
    end
    csr_req = 0; csr_we = 0; #1;
    checks++;
    if (csr_gnt !== 1'b0 || pc_addr !== 12'd0) begin errors++; $display("FAIL idle_port gnt=%b addr=%h", csr_gnt, pc_addr); end
  endtask

  task automatic test_basic();
    int n;
    do_reset();
    en = 1; period = 10; mask = 6'b000101; ready = 1;
    tick(); n = 0;
    while (!smp_valid && n < 40) begin tick(); n++; end
    checks++;
    if (n !== 11) begin errors++; $display("FAIL basic_latency got %0d exp 11", n); end
    checks++;
    if (smp_idx !== 3'd0 || smp_last !== 1'b0 || smp_data[63:52] !== 12'hB03) begin
      errors++; $display("FAIL basic_beat0 idx=%0d last=%b addr=%h", smp_idx, smp_last, smp_data[63:52]);
    end
    tick(); tick();
    checks++;
    if (smp_valid !== 1'b1 || smp_idx !== 3'd2 || smp_last !== 1'b1 || smp_data[63:52] !== 12'hB05) begin
      errors++; $display("FAIL basic_beat1 v=%b idx=%0d last=%b addr=%h", smp_valid, smp_idx, smp_last, smp_data[63:52]);
    end
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++;
      if (dut_vec !== mdl_vec) begin errors++; $display("FAIL basic_model got %h exp %h", dut_vec, mdl_vec); end
    end
    checks++;
    if (smp_seq !== 16'd1) begin errors++; $display("FAIL basic_seq got %0d exp 1", smp_seq); end
  endtask

  task automatic test_csr_stall();
    int n;
    logic [31:0] rel_cyc;
    do_reset();
    en = 1; period = 10; mask = 6'b000100; ready = 1;
    n = 0;
    while (!busy && n < 40) begin tick(); n++; end
    checks++;
    if (!busy) begin errors++; $display("FAIL stall_reach_scan busy=%b exp 1", busy); end
    for (int i = 0; i < 3; i++) begin
      csr_req = 1; csr_addr = 12'($urandom); csr_we = 0; csr_wdata = {$urandom, $urandom}; #1;
      checks++;
      if (csr_gnt !== 1'b1 || pc_addr !== csr_addr || csr_rdata !== {csr_addr, 1'b0, 19'd0, cyc}) begin
        errors++; $display("FAIL stall_csr gnt=%b addr=%h exp %h rdata=%h", csr_gnt, pc_addr, csr_addr, csr_rdata);
      end
      tick();
      checks++;
      if (smp_valid !== 1'b0 || dut_vec !== mdl_vec) begin
        errors++; $display("FAIL stall_hold valid=%b got %h exp %h", smp_valid, dut_vec, mdl_vec);
      end
    end
    csr_req = 0; #1;
    rel_cyc = cyc;
    tick();
    checks++;
    if (smp_valid !== 1'b1 || smp_data !== {12'hB05, 1'b0, 19'd0, rel_cyc}) begin
      errors++; $display("FAIL stall_release valid=%b data=%h exp %h", smp_valid, smp_data, {12'hB05, 1'b0, 19'd0, rel_cyc});
    end
  endtask

  task automatic test_overrun();
    int n;
    logic [63:0] held;
    do_reset();
    en = 1; period = 4; mask = 6'b111111; ready = 0;
    n = 0;
    while (!smp_valid && n < 30) begin tick(); n++; end
    held = smp_data;
    for (int i = 0; i < 20; i++) begin
      tick();
      checks++;
      if (smp_valid !== 1'b1 || smp_data !== held || dut_vec !== mdl_vec) begin
        errors++; $display("FAIL ovr_hold v=%b got %h exp %h", smp_valid, dut_vec, mdl_vec);
      end
    end
    checks++;
    if (overrun !== 16'd5) begin errors++; $display("FAIL ovr_count got %0d exp 5", overrun); end
    period = 1;
    for (int i = 0; i < 65600; i++) tick();
    checks++;
    if (overrun !== 16'hFFFF || smp_valid !== 1'b1 || smp_data !== held) begin
      errors++; $display("FAIL ovr_saturate ovf=%h v=%b exp FFFF 1", overrun, smp_valid);
    end
  endtask

  task automatic test_mask_zero();
    int last_chg, gap_bad, chgs;
    logic [15:0] prev;
    do_reset();
    en = 1; period = 3; mask = 0; ready = 1;
    last_chg = -1; gap_bad = 0; chgs = 0; prev = smp_seq;
    for (int i = 0; i < 30; i++) begin
      tick();
      checks++;
      if (smp_valid !== 1'b0 || dut_vec !== mdl_vec) begin
        errors++; $display("FAIL mask0_model v=%b got %h exp %h", smp_valid, dut_vec, mdl_vec);
      end
      if (smp_seq != prev) begin
        if (last_chg >= 0 && i - last_chg != 3) gap_bad++;
        last_chg = i; prev = smp_seq; chgs++;
      end
    end
    checks++;
    if (gap_bad != 0 || chgs < 8) begin errors++; $display("FAIL mask0_period bad_gaps=%0d incs=%0d exp 0 >=8", gap_bad, chgs); end
  endtask

  task automatic test_en_drop();
    int n;
    logic [63:0] held;
    logic [15:0] seq0;
    do_reset();
    en = 1; period = 5; mask = 6'b000011; ready = 0;
    n = 0;
    while (!smp_valid && n < 30) begin tick(); n++; end
    held = smp_data; seq0 = smp_seq;
    en = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++;
      if (smp_valid !== 1'b1 || smp_data !== held) begin errors++; $display("FAIL endrop_hold v=%b data=%h exp 1 %h", smp_valid, smp_data, held); end
    end
    ready = 1;
    tick();
    checks++;
    if (smp_valid !== 1'b0 || busy !== 1'b0 || smp_seq !== seq0) begin
      errors++; $display("FAIL endrop_idle v=%b busy=%b seq=%0d exp 0 0 %0d", smp_valid, busy, smp_seq, seq0);
    end
    tick(); tick();
    checks++;
    if (busy !== 1'b0 || dut_vec !== mdl_vec) begin errors++; $display("FAIL endrop_stay got %h exp %h", dut_vec, mdl_vec); end
  endtask

  task automatic test_reset_mid_send();
    int n;
    do_reset();
    en = 1; period = 3; mask = 6'b010000; ready = 0;
    n = 0;
    while (!smp_valid && n < 30) begin tick(); n++; end
    rst_n = 0; csr_req = 1; csr_addr = 12'hC00; csr_we = 0; #1;
    checks++;
    if (csr_gnt !== 1'b1) begin errors++; $display("FAIL rstsend_gnt got %b exp 1", csr_gnt); end
    tick();
    checks++;
    if (dut_vec !== 102'd0 || csr_gnt !== 1'b1) begin errors++; $display("FAIL rstsend_state got %h gnt=%b exp 0 1", dut_vec, csr_gnt); end
    rst_n = 1; csr_req = 0;
  endtask

  task automatic test_random();
    logic [11:0] e_addr;
    int fk;
    do_reset();
    period = 3;
    for (int i = 0; i < 3000; i++) begin
      en = ($urandom_range(0, 19) != 0);
      if ($urandom_range(0, 49) == 0) period = $urandom_range(0, 8);
      mask = NC'($urandom);
      ready = $urandom_range(0, 1);
      csr_req = ($urandom_range(0, 4) == 0);
      csr_addr = 12'($urandom); csr_we = $urandom_range(0, 1); csr_wdata = {$urandom, $urandom};
      #1;
      fk = -1;
      for (int j = NC - 1; j >= m_idx; j--) if (m_mask[j]) fk = j;
      e_addr = csr_req ? csr_addr : (m_state == 2 && fk >= 0) ? 12'hB03 + 12'(fk) : 12'd0;
      checks++;
      if (csr_gnt !== csr_req || pc_addr !== e_addr || pc_we !== (csr_req & csr_we)) begin
        errors++; $display("FAIL rand_port gnt=%b addr=%h exp %b %h", csr_gnt, pc_addr, csr_req, e_addr);
      end
      tick();
      checks++;
      if (dut_vec !== mdl_vec) begin errors++; $display("FAIL rand_model cyc %0d got %h exp %h", i, dut_vec, mdl_vec); end
    end
  endtask

  initial begin
    cyc = 0; rst_n = 0; csr_req = 0; csr_addr = 0; csr_we = 0; csr_wdata = 0;
    en = 0; period = 1; mask = 0; ready = 0;
    test_reset();
    test_basic();
    test_csr_stall();
    test_mask_zero();
    test_en_drop();
    test_reset_mid_send();
    test_random();
    test_overrun();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/hpm_sample_sequencer.md
HPM_SAMPLE_SEQUENCER -- requirements
Module: hpm_sample_sequencer

Interface
REQ-001 Parameter NumCounters, 6, number of programmable HPM counters scanned (mhpmcounter3..3+NumCounters-1).
REQ-002 Parameter OvfWidth, 16, width of the overrun counter.
REQ-003 Clock and reset: one clock; reset is synchronous and active-low.
REQ-004 clk_i  in  1  clock.
REQ-005 rst_ni  in  1  synchronous active-low reset.
REQ-006 csr_req_i  in  1  CSR-unit access request to the perf-counter port.
REQ-007 csr_addr_i  in  12  CSR address.
REQ-008 csr_we_i  in  1  CSR write enable.
REQ-009 csr_wdata_i  in  64  CSR write data.
REQ-010 csr_gnt_o  out  1  CSR access granted this cycle.
REQ-011 csr_rdata_o  out  64  CSR read data.
REQ-012 cfg_en_i  in  1  sampler enable.
REQ-013 cfg_period_i  in  32  sampling period in cycles.
REQ-014 cfg_mask_i  in  NumCounters  counter select mask, bit k = mhpmcounter(3+k).
REQ-015 pc_addr_o  out  12  address to perf-counter port.
REQ-016 pc_we_o  out  1  write enable to perf-counter port.
REQ-017 pc_wdata_o  out  64  write data to perf-counter port.
REQ-018 pc_rdata_i  in  64  combinational read data from perf-counter port.
REQ-019 smp_valid_o  out  1  sample beat valid.
REQ-020 smp_ready_i  in  1  sample consumer ready.
REQ-021 smp_idx_o  out  $clog2(NumCounters)  counter index k of beat.
REQ-022 smp_data_o  out  64  sampled counter value.
REQ-023 smp_last_o  out  1  last beat of current scan.
REQ-024 smp_seq_o  out  16  scan sequence number, constant during a scan.
REQ-025 overrun_o  out  OvfWidth  count of period expiries dropped.
REQ-026 busy_o  out  1  high in SCAN or SEND.

Function
REQ-027 Arbitration: csr_req_i has absolute priority; csr_gnt_o = csr_req_i combinationally; CSR never stalls.
REQ-028 When csr_req_i=1: pc_addr_o=csr_addr_i, pc_we_o=csr_we_i, pc_wdata_o=csr_wdata_i, csr_rdata_o=pc_rdata_i.
REQ-029 When csr_req_i=0 and state SCAN with a selected counter: pc_addr_o=12'hB03+idx, pc_we_o=0; otherwise pc_addr_o=0, pc_we_o=0, pc_wdata_o=0.
REQ-030 States: IDLE, COUNT, SCAN, SEND.
REQ-031 IDLE: cfg_en_i=1 -> load timer with max(cfg_period_i,1), go COUNT.
REQ-032 Timer decrements every cycle in COUNT, SCAN and SEND; at value 1 it expires and reloads max(cfg_period_i,1) the next cycle.
REQ-033 COUNT: expiry -> latch cfg_mask_i into scan mask, idx=0, go SCAN; cfg_en_i=0 -> IDLE (takes precedence).
REQ-034 SCAN: find lowest set scan-mask bit >= idx; none -> smp_seq_o+=1 (wraps 16-bit), go COUNT (IDLE if cfg_en_i=0).
REQ-035 SCAN with bit k found and csr_req_i=0: capture pc_rdata_i into smp_data_o, idx=k, go SEND; csr_req_i=1 -> hold in SCAN.
REQ-036 SEND: smp_valid_o=1; smp_idx_o, smp_data_o, smp_last_o stable until smp_valid_o&smp_ready_i.
REQ-037 SEND handshake: idx=k+1, go SCAN; cfg_en_i=0 at handshake -> IDLE without incrementing smp_seq_o.
REQ-038 smp_last_o=1 iff no scan-mask bit above k is set.
REQ-039 Timer expiry while in SCAN or SEND: overrun_o += 1, saturating at all-ones; scan continues undisturbed.
REQ-040 cfg_en_i=0 in SCAN -> IDLE next cycle; in SEND it is honoured only at handshake (valid never withdrawn).
REQ-041 Scan mask all-zero: SCAN completes in one cycle with no beats, smp_seq_o increments.
REQ-042 busy_o=1 in SCAN or SEND, else 0.

Reset
REQ-043 rst_ni=0 at clock edge: state IDLE, timer 0, idx 0, scan mask 0, smp_valid_o 0, smp_data_o 0, smp_idx_o 0, smp_last_o 0, smp_seq_o 0, overrun_o 0, busy_o 0; reset mid-SEND drops the beat.

Verification
REQ-044 en=1, period=10, mask=6'b000101, ready=1 -> beats idx0 then idx2 (last=1), first valid 11 cycles after enable, smp_seq_o 0->1.
REQ-045 csr_req_i held 3 cycles during SCAN -> csr_gnt_o=1 each cycle, pc_addr_o=csr_addr_i, sampler beat delayed by exactly 3 cycles, data from cycle after release.
REQ-046 period=4, mask=6'b111111, ready=0 for 20 cycles -> valid/data held stable, overrun_o=5, saturates at 16'hFFFF under long stall.
REQ-047 mask=0, period=3 -> no smp_valid_o ever, smp_seq_o increments every 3 cycles.
REQ-048 cfg_en_i dropped during SEND with ready=0 -> valid held until ready, then IDLE, smp_seq_o unchanged.
REQ-049 rst_ni=0 asserted mid-SEND -> next cycle all outputs at REQ-043 values, csr_gnt_o still follows csr_req_i.
